// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle via an external adder.
// Optional DIV_EARLY_OUT_EN: finish on the cycle after start when |rs1| < |rs2|.
module div_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_cin,
  input  logic [XLEN-1:0] add_s,
  input  logic            add_cout,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] q_q, q_d, d_q, d_d, r_q, r_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;

  logic            signed_op, div_zero, ovf, take;
  logic [XLEN-1:0] abs_a, abs_b, sh;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op & rs1[XLEN-1]) ? negate(rs1) : rs1;
    abs_b     = (signed_op & rs2[XLEN-1]) ? negate(rs2) : rs2;
    div_zero  = (rs2 == '0);
    ovf       = signed_op & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    sh        = {r_q[XLEN-2:0], q_q[XLEN-1]};
    // R msb set means the 33-bit shifted remainder already exceeds any divisor.
    take      = r_q[XLEN-1] | add_cout;

    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_CALC) begin
      add_a   = sh;
      add_b   = ~d_q;
      add_cin = 1'b1;
    end

    state_d  = state_q;
    q_d      = q_q;
    d_d      = d_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            q_d    = abs_a;
            d_d    = abs_b;
            r_d    = '0;
            cnt_d  = '0;
            op_d   = op;
            qneg_d = signed_op & (rs1[XLEN-1] ^ rs2[XLEN-1]) & ~div_zero;
            rneg_d = signed_op & rs1[XLEN-1];
            if (div_zero) begin
              result_d = op[1] ? rs1 : '1;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = op[1] ? '0 : rs1;
              state_d  = S_DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (abs_a < abs_b) begin
              result_d = op[1] ? rs1 : '0;
              state_d  = S_DONE;
            end
`endif
            else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          r_d   = take ? add_s : sh;
          q_d   = {q_q[XLEN-2:0], take};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = op_q[1] ? (rneg_q ? negate(r_q) : r_q)
                             : (qneg_q ? negate(q_q) : q_q);
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      d_q      <= d_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed-vector bench for div_iter_unit with a behavioural adder on the add_* port.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [31:0] add_a, add_b, add_s, result;
  logic        add_cin, add_cout, busy, done;

  int errs = 0;
  int checks = 0;
  int cyc;
  int dones;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_iter_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .rs1(rs1), .rs2(rs2), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .busy(busy), .done(done), .result(result)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch from a cycle where the unit accepts; returns #1 after the edge that shows done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    if (exp_lat > 1) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " cin"}, {31'd0, add_cin}, 32'd1);
    end
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, " lat"}, cyc, exp_lat);
    check({tag, " res"}, result, exp_res);
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst add_a", add_a, 32'd0);
    check("rst add_b", add_b, 32'd0);
    check("rst add_cin", {31'd0, add_cin}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 34);
    step();
    check("done pulse", {31'd0, done}, 32'd0);
    check("idle add_cin", {31'd0, add_cin}, 32'd0);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 34);
    step();
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    step();
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    step();
    run_op("div 20/-3", DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    step();
    run_op("rem -20/3", REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
    step();
    run_op("divu big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);
    step();
    run_op("remu big", REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
    step();
    run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    step();
    run_op("rem 5/0", REM, 32'd5, 32'd0, 32'd5, 1);
    step();
    run_op("remu x/0", REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
    step();
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    step();
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    step();
`ifdef DIV_EARLY_OUT_EN
    run_op("divu 3/9", DIVU, 32'd3, 32'd9, 32'd0, 1);
    step();
    run_op("rem -3/9", REM, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 1);
    step();
`else
    run_op("divu 3/9", DIVU, 32'd3, 32'd9, 32'd0, 34);
    step();
    run_op("rem -3/9", REM, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 34);
    step();
`endif

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op("b2b first", DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("b2b second", REMU, 32'd1000, 32'd7, 32'd6, 34);
    step();

    // Kill in flight: old result survives, no done ever appears.
    op = DIVU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    check("kill result", result, 32'd6);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      step();
    end
    check("kill no done", dones, 32'd0);
    run_op("after kill", DIVU, 32'd100, 32'd7, 32'd14, 34);
    step();

    // Start while busy must not disturb the running divide.
    op = DIVU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    repeat (4) begin step(); cyc++; end
    op = DIV; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
    step();
    cyc++;
    start = 1'b0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check("busy start lat", cyc, 32'd34);
    check("busy start res", result, 32'd142);
    step();

    // Asynchronous reset mid-operation.
    op = DIVU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst result", result, 32'd0);
    check("arst add_a", add_a, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("after rst", DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
